div_restoring: RTL and testbench
================================

Name: div_restoring

Overview:
- Sequential unsigned restoring divider, N-bit dividend / N-bit divisor -> N-bit quotient + N-bit remainder.
- Inverse companion of the Booth multiplier: same shift/operate alternating control style, two cycles per bit.
- Sits beside the multiplier in the arithmetic unit; driven by the same start/fin handshake.

Parameters:
- N, 4, operand width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  synchronous request; sampled only in IDLE or DONE
- dividend  input  N  dividend, captured in LOAD
- divisor  input  N  divisor, captured in LOAD
- quotient  output  N  result quotient, valid while fin=1
- remainder  output  N  result remainder, valid while fin=1
- busy  output  1  high in LOAD, SHIFT, SUB
- fin  output  1  high in DONE
- div_zero  output  1  divisor-was-zero flag; see Optional Feature

Behaviour:
- Registers: A (N+1 bits, partial remainder), Q (N bits), M (N bits), cnt (ceil(log2(N+1)) bits), state.
- Reset (async, any state): state=IDLE, A=0, Q=0, M=0, cnt=0. All outputs are 0.
- States and transitions:
  - IDLE: start=1 -> LOAD; otherwise hold.
  - LOAD: A<=0, Q<=dividend, M<=divisor, cnt<=N -> SHIFT.
  - SHIFT: {A,Q} <= {A,Q}<<1 (Q[0]<=0) -> SUB.
  - SUB: T = A - {1'b0,M} in N+1 bits.
    - T[N]=0: A<=T, Q[0]<=1.
    - T[N]=1: A unchanged (non-performing restore), Q[0] stays 0.
    - cnt<=cnt-1; if cnt==1 -> DONE, else -> SHIFT.
  - DONE: hold results. start=1 -> LOAD; otherwise stay in DONE.
- Latency: start high in IDLE at edge k -> LOAD at k+1 -> fin=1 from edge k+2+2N. For N=4, fin asserts 10 cycles after the start edge.
- Outputs: quotient=Q, remainder=A[N-1:0]. They are meaningful only when fin=1 and must not be sampled while busy.
- start while busy is ignored. A restart from DONE clears fin on the next edge.
- A[N] is always 0 at DONE, so the remainder fits in N bits.
- Reset mid-operation aborts immediately. No partial result is retained.
- Divisor 0 without the feature: the algorithm runs the full 2N cycles, giving quotient = all ones and remainder = dividend; div_zero stays 0.

Optional Feature:
- Macro DIV_ZERO_CHECK_EN.
- Defined:
  - LOAD checks divisor==0. If zero, it goes directly to DONE with Q<=all ones, A<={1'b0,dividend}, and div_zero register <=1.
  - Latency is 2 cycles from the start edge.
  - div_zero clears in the next LOAD and on reset.
- Undefined: div_zero is tied to 0, with no early exit. The values at DONE are identical to the defined case, only later.

Decomposition:
- Package div_pkg: state encoding constants (IDLE, LOAD, SHIFT, SUB, DONE; 3-bit) and default width N.
- One natural sub-module, div_uc: state register, cnt, decoding of control strobes (load, shift, sub_en, fin, busy).
- The top level holds the A/Q/M datapath and the subtractor.

Test Plan:
- N=4, dividend=13, divisor=3, start pulse -> fin after 10 cycles, quotient=4, remainder=1, busy low at fin.
- 15/1 -> quotient=15, remainder=0; 7/9 -> quotient=0, remainder=7; 0/5 -> quotient=0, remainder=0.
- 9/0:
  - Without the macro: quotient=15, remainder=9 after 10 cycles, div_zero=0.
  - With DIV_ZERO_CHECK_EN: same values after 2 cycles, div_zero=1.
- start re-pulsed during SUB (for example 13/3 in flight) -> ignored, result still 4 r 1 with unchanged latency.
- reset asserted mid-SHIFT -> outputs 0 immediately. After release, a new start with 12/5 -> quotient=2, remainder=2.
- Back-to-back: start held high in DONE after 13/3 -> re-enters LOAD, fin drops for one operation, new result uses new operands (10/4 -> 2 r 2).

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: default operand width and
// the 3-bit state encoding used by the control unit.
package div_pkg;

    // Default operand width in bits (must be >= 2).
    localparam int DIV_N = 4;

    // Control state encoding.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_SUB   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Width of the iteration counter: it holds values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_uc.sv
// Control unit of the restoring divider: state register, iteration counter
// and decoding of the datapath strobes. Two cycles per quotient bit
// (SHIFT then SUB). With DIV_ZERO_CHECK_EN defined, LOAD exits straight to
// DONE when the divisor is zero. The current state is exported on state_dbg.
import div_pkg::*;

module div_uc #(
    parameter int N  = DIV_N,
    parameter int CW = cnt_width(N)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef DIV_ZERO_CHECK_EN
    input  logic       zero_div,
`endif
    output logic       load,
    output logic       shift,
    output logic       sub_en,
    output logic       fin,
    output logic       busy,
    output logic [2:0] state_dbg
);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;

    // Next-state selection; start is only honoured in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD: begin
`ifdef DIV_ZERO_CHECK_EN
                if (zero_div) state_nxt = S_DONE;
                else          state_nxt = S_SHIFT;
`else
                state_nxt = S_SHIFT;
`endif
            end
            S_SHIFT: state_nxt = S_SUB;
            S_SUB:   state_nxt = (cnt == CW'(1)) ? S_DONE : S_SHIFT;
            S_DONE:  if (start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and iteration counter (one count per quotient bit).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_LOAD)
                cnt <= CW'(N);
            else if (state == S_SUB)
                cnt <= cnt - CW'(1);
        end
    end

    assign load      = (state == S_LOAD);
    assign shift     = (state == S_SHIFT);
    assign sub_en    = (state == S_SUB);
    assign fin       = (state == S_DONE);
    assign busy      = load | shift | sub_en;
    assign state_dbg = state;

endmodule

// File: rtl/div_restoring.sv
// Sequential unsigned restoring divider: N-bit dividend / N-bit divisor
// giving N-bit quotient and remainder, two cycles per bit.
// Optional build macro: DIV_ZERO_CHECK_EN (early exit on a zero divisor
// with the div_zero flag raised).
//
// Handshake: pulse or hold start while fin=1 or in idle; the operands are
// captured one cycle later (LOAD). busy is high while the operation runs and
// start is ignored then. fin stays high with stable quotient/remainder until
// the next start, whose first edge drops fin again.
import div_pkg::*;

module div_restoring #(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         fin,
    output logic         div_zero
);

    logic [N:0]   a;      // partial remainder, one guard bit
    logic [N-1:0] q;      // dividend shifting out, quotient shifting in
    logic [N-1:0] m;      // captured divisor
    logic [N:0]   t;      // trial subtraction result
    logic         load;
    logic         shift;
    logic         sub_en;
    logic [2:0]   fsm_state;

`ifdef DIV_ZERO_CHECK_EN
    logic zero_div;
    assign zero_div = (divisor == '0);
`endif

    div_uc #(.N(N)) u_uc (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef DIV_ZERO_CHECK_EN
        .zero_div  (zero_div),
`endif
        .load      (load),
        .shift     (shift),
        .sub_en    (sub_en),
        .fin       (fin),
        .busy      (busy),
        .state_dbg (fsm_state)
    );

    // Trial subtraction; bit N set means the divisor did not fit.
    assign t = a - {1'b0, m};

    // A/Q/M datapath: load operands, shift pair left, conditionally subtract.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a <= '0;
            q <= '0;
            m <= '0;
        end else if (load) begin
            a <= '0;
            q <= dividend;
            m <= divisor;
`ifdef DIV_ZERO_CHECK_EN
            if (divisor == '0) begin
                a <= {1'b0, dividend};
                q <= '1;
            end
`endif
        end else if (shift) begin
            a <= {a[N-1:0], q[N-1]};
            q <= {q[N-2:0], 1'b0};
        end else if (sub_en) begin
            if (!t[N]) begin
                a    <= t;
                q[0] <= 1'b1;
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    // Zero-divisor flag: decided at every LOAD, held through DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_zero <= 1'b0;
        else if (load)
            div_zero <= (divisor == '0);
    end
`else
    assign div_zero = 1'b0;
`endif

    assign quotient  = q;
    assign remainder = a[N-1:0];

    // a[N] is always 0 once the result is ready; the state is a debug tap.
    logic unused_bits;
    assign unused_bits = ^{a[N], fsm_state};

endmodule

// File: tb/tb_div_restoring.sv
// Self-checking bench for div_restoring: directed cases, randomized operands
// against an arithmetic reference model, start-while-busy, mid-run reset and
// back-to-back restarts from DONE.
module tb_div_restoring;

    localparam int N        = 4;
    localparam int LAT_FULL = 2 * N + 2;
    localparam int MAX_WAIT = 60;

`ifdef DIV_ZERO_CHECK_EN
    localparam bit zero_check = 1'b1;
`else
    localparam bit zero_check = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         fin;
    logic         div_zero;

    int total = 0;
    int bad   = 0;
    logic [2*N-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    div_restoring #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .fin       (fin),
        .div_zero  (div_zero)
    );

    // ---------------- reference model ----------------
    function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
        int qi;
        int ri;
        if (y == 0) begin
            qi = (1 << N) - 1;
            ri = int'(x);
        end else begin
            qi = int'(x) / int'(y);
            ri = int'(x) % int'(y);
        end
        return {qi[N-1:0], ri[N-1:0]};
    endfunction

    function automatic int model_lat(input logic [N-1:0] y);
        return (zero_check && y == 0) ? 2 : LAT_FULL;
    endfunction

    function automatic logic model_dz(input logic [N-1:0] y);
        return zero_check && (y == 0);
    endfunction

    // ---------------- driver ----------------
    // Raises start for one edge and counts edges (the sampling edge is 1)
    // until fin is seen, or gives up after MAX_WAIT edges.
    task automatic do_div(input logic [N-1:0] x, input logic [N-1:0] y,
                          output int lat, output logic fin_first, output logic timed_out);
        @(negedge clk);
        dividend = x;
        divisor  = y;
        start    = 1'b1;
        lat       = 0;
        timed_out = 1'b1;
        fin_first = 1'b0;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                start     = 1'b0;
                fin_first = fin;
            end
            if (fin) begin
                lat       = i;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({quotient, remainder, busy, fin, div_zero} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b fin=%b dz=%b required all 0",
                     quotient, remainder, busy, fin, div_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, fin} !== 2'b00) begin
            bad++;
            $display("FAIL idle_hold: got busy=%b fin=%b required 0 0", busy, fin);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [6] = '{4'd13, 4'd15, 4'd7, 4'd0, 4'd9, 4'd12};
        logic [N-1:0] tb [6] = '{4'd3,  4'd1,  4'd9, 4'd5, 4'd0, 4'd5};
        int lat;
        logic ff;
        logic to;
        logic [2*N-1:0] e;
        for (int k = 0; k < 6; k++) begin
            e = model(ta[k], tb[k]);
            do_div(ta[k], tb[k], lat, ff, to);
            total++;
            if (to !== 1'b0) begin
                bad++;
                $display("FAIL directed_timeout %0d/%0d: fin not seen within %0d edges", ta[k], tb[k], MAX_WAIT);
            end
            total++;
            if ({quotient, remainder} !== e) begin
                bad++;
                $display("FAIL directed_result %0d/%0d: got q=%0d r=%0d required q=%0d r=%0d",
                         ta[k], tb[k], quotient, remainder, e[2*N-1:N], e[N-1:0]);
            end
            total++;
            if (lat !== model_lat(tb[k])) begin
                bad++;
                $display("FAIL directed_latency %0d/%0d: got %0d required %0d", ta[k], tb[k], lat, model_lat(tb[k]));
            end
            total++;
            if (div_zero !== model_dz(tb[k])) begin
                bad++;
                $display("FAIL directed_div_zero %0d/%0d: got %b required %b", ta[k], tb[k], div_zero, model_dz(tb[k]));
            end
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL directed_busy_at_fin %0d/%0d: got %b required 0", ta[k], tb[k], busy);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic ff;
        logic to;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [2*N-1:0] e;
        for (int k = 0; k < 24; k++) begin
            x = N'($urandom_range(0, (1 << N) - 1));
            y = N'($urandom_range(0, (1 << N) - 1));
            exp_q.push_back(model(x, y));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_div(x, y, lat, ff, to);
            e = exp_q.pop_front();
            total++;
            if (to !== 1'b0 || {quotient, remainder} !== e) begin
                bad++;
                $display("FAIL random_result %0d/%0d: got q=%0d r=%0d timeout=%b required q=%0d r=%0d",
                         x, y, quotient, remainder, to, e[2*N-1:N], e[N-1:0]);
            end
            total++;
            if (lat !== model_lat(y) || div_zero !== model_dz(y)) begin
                bad++;
                $display("FAIL random_timing %0d/%0d: got lat=%0d dz=%b required lat=%0d dz=%b",
                         x, y, lat, div_zero, model_lat(y), model_dz(y));
            end
        end
    endtask

    task automatic test_start_during_busy();
        int lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
            if (i == 3) begin
                dividend = 4'd2;
                divisor  = 4'd1;
                start    = 1'b1;
            end
            if (i == 6) start = 1'b0;
            if (fin) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        total++;
        if (seen !== 1'b1 || {quotient, remainder} !== {4'd4, 4'd1}) begin
            bad++;
            $display("FAIL busy_start_result: got q=%0d r=%0d seen=%b required q=4 r=1",
                     quotient, remainder, seen);
        end
        total++;
        if (lat !== LAT_FULL) begin
            bad++;
            $display("FAIL busy_start_latency: got %0d required %0d", lat, LAT_FULL);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic ff;
        logic to;
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy_before_reset: got %b required 1", busy);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({quotient, remainder, busy, fin, div_zero} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got q=%0d r=%0d busy=%b fin=%b dz=%b required all 0",
                     quotient, remainder, busy, fin, div_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({busy, fin} !== 2'b00) begin
            bad++;
            $display("FAIL mid_after_release: got busy=%b fin=%b required 0 0", busy, fin);
        end
        do_div(4'd12, 4'd5, lat, ff, to);
        total++;
        if (to !== 1'b0 || {quotient, remainder} !== model(4'd12, 4'd5) || lat !== LAT_FULL) begin
            bad++;
            $display("FAIL mid_restart_12_5: got q=%0d r=%0d lat=%0d timeout=%b required q=2 r=2 lat=%0d",
                     quotient, remainder, lat, to, LAT_FULL);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic ff;
        logic to;
        do_div(4'd13, 4'd3, lat, ff, to);
        total++;
        if (to !== 1'b0 || {quotient, remainder} !== {4'd4, 4'd1}) begin
            bad++;
            $display("FAIL b2b_first: got q=%0d r=%0d timeout=%b required q=4 r=1", quotient, remainder, to);
        end
        do_div(4'd10, 4'd4, lat, ff, to);
        total++;
        if (ff !== 1'b0) begin
            bad++;
            $display("FAIL b2b_fin_drop: got fin=%b after restart edge required 0", ff);
        end
        total++;
        if (to !== 1'b0 || {quotient, remainder} !== {4'd2, 4'd2}) begin
            bad++;
            $display("FAIL b2b_second: got q=%0d r=%0d timeout=%b required q=2 r=2", quotient, remainder, to);
        end
        total++;
        if (lat !== LAT_FULL) begin
            bad++;
            $display("FAIL b2b_latency: got %0d required %0d", lat, LAT_FULL);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_during_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
